// File: rtl/dem_tree_scheduler.sv
// Time-multiplexes one external DEM switching block across every node of a
// binary encoder tree, breadth-first, and emits the unary DAC cell-enable word.
module dem_tree_scheduler #(
   parameter int          LAYERS    = 3,
   parameter int          WIDTH     = 8,
   parameter int          TIMEOUT   = 15,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [WIDTH-1:0]     in_sample_i,
   output logic                 sb_req_o,
   output logic [LAYERS-1:0]    sb_node_o,
   output logic [WIDTH-1:0]     sb_x_o,
   output logic                 sb_pn_o,
   input  logic                 sb_ack_i,
   input  logic [WIDTH-1:0]     sb_out1_i,
   input  logic [WIDTH-1:0]     sb_out2_i,
   output logic [2**LAYERS-1:0] cells_o,
   output logic                 out_valid_o,
   output logic                 err_o
);

   localparam int N     = 2**LAYERS - 1;
   localparam int CELLS = 2**LAYERS;
   localparam int IW    = LAYERS + 1;
   localparam int NVAL  = 2**IW;
   localparam int TW    = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t              state_reg, state_next;
   logic [WIDTH-1:0]    val_reg [NVAL];
   logic [LAYERS-1:0]   k_reg;
   logic [TW-1:0]       tmo_reg;
   logic [15:0]         lfsr_reg;
   logic [WIDTH-1:0]    sample_reg;
   logic [LAYERS-1:0]   node_hold_reg;
   logic [WIDTH-1:0]    x_hold_reg;
   logic                pn_hold_reg;
   logic [CELLS-1:0]    cells_reg;
   logic                err_reg;

   logic                accept, ack_ok, tmo_hit, last_node, clamp, lfsr_fb, conserve_bad;
   logic [WIDTH-1:0]    sample_clamped;
   logic [IW-1:0]       idx_left, idx_right;
   logic [CELLS-1:0]    cells_new, leaf_big;

   assign accept         = (state_reg == IDLE) && in_valid_i;
   assign ack_ok         = (state_reg == WAIT) && sb_ack_i;
   assign tmo_hit        = (state_reg == WAIT) && !sb_ack_i && (tmo_reg == TW'(TIMEOUT - 1));
   assign last_node      = (k_reg == LAYERS'(N));
   assign clamp          = (in_sample_i > WIDTH'(CELLS));
   assign sample_clamped = clamp ? WIDTH'(CELLS) : in_sample_i;
   assign idx_left       = {k_reg, 1'b0};
   assign idx_right      = {k_reg, 1'b1};
   assign lfsr_fb        = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];
   assign conserve_bad   = (WIDTH'($countones(cells_reg)) != sample_reg);

   // Leaf view forwards the final ack's results so cells_o lands together with out_valid_o.
   generate
      for (genvar gi = 0; gi < CELLS; gi++) begin : g_leaf
         localparam logic [IW-1:0] LIDX = IW'(N + 1 + gi);
         logic [WIDTH-1:0] leaf_val;
         always_comb begin
            leaf_val = val_reg[LIDX];
            if (ack_ok && (idx_left == LIDX))
               leaf_val = sb_out1_i;
            if (ack_ok && (idx_right == LIDX))
               leaf_val = sb_out2_i;
         end
         assign cells_new[gi] = |leaf_val;
         assign leaf_big[gi]  = (val_reg[LIDX] > WIDTH'(1));
      end
   endgenerate

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (in_valid_i) state_next = ISSUE;
         ISSUE:   state_next = WAIT;
         WAIT: begin
            if (sb_ack_i)
               state_next = last_node ? DONE : ISSUE;
            else if (tmo_hit)
               state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready_o  = (state_reg == IDLE);
      sb_req_o    = (state_reg == ISSUE);
      out_valid_o = (state_reg == DONE);
      sb_node_o   = node_hold_reg;
      sb_x_o      = x_hold_reg;
      sb_pn_o     = pn_hold_reg;
      if (state_reg == ISSUE) begin
         sb_node_o = k_reg;
         sb_x_o    = val_reg[{1'b0, k_reg}];
         sb_pn_o   = lfsr_reg[0];
      end
   end

   assign cells_o = cells_reg;
   assign err_o   = err_reg;

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         for (int i = 0; i < NVAL; i++)
            val_reg[i] <= '0;
      end else begin
         if (accept)
            val_reg[1] <= sample_clamped;
         if (ack_ok) begin
            val_reg[idx_left]  <= sb_out1_i;
            val_reg[idx_right] <= sb_out2_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         k_reg         <= '0;
         tmo_reg       <= '0;
         lfsr_reg      <= LFSR_SEED;
         sample_reg    <= '0;
         node_hold_reg <= '0;
         x_hold_reg    <= '0;
         pn_hold_reg   <= 1'b0;
         cells_reg     <= '0;
         err_reg       <= 1'b0;
      end else begin
         if (accept) begin
            k_reg      <= LAYERS'(1);
            sample_reg <= sample_clamped;
            if (clamp)
               err_reg <= 1'b1;
         end
         if (state_reg == ISSUE) begin
            lfsr_reg      <= {lfsr_reg[14:0], lfsr_fb};
            tmo_reg       <= '0;
            node_hold_reg <= k_reg;
            x_hold_reg    <= val_reg[{1'b0, k_reg}];
            pn_hold_reg   <= lfsr_reg[0];
         end
         if ((state_reg == WAIT) && !sb_ack_i && !tmo_hit)
            tmo_reg <= tmo_reg + 1'b1;
         if (ack_ok) begin
            if (last_node)
               cells_reg <= cells_new;
            else
               k_reg <= k_reg + 1'b1;
         end
         if (tmo_hit) begin
            err_reg   <= 1'b1;
            cells_reg <= '0;
         end
         // Leaves above 1 or a lost/extra unit both mean the tree did not conserve the sample.
         if ((state_reg == DONE) && ((|leaf_big) || conserve_bad))
            err_reg <= 1'b1;
      end
   end

endmodule
